timer_entrada_param: RTL and testbench

Parametrised keypad entry and timebase controller for the oven timer path. It sits between the 10-key one-hot keypad and the BCD down-counter chain. It encodes each new key press to BCD and pulses `loadn`. It also shifts the digit into a DIGITS-wide entry register and generates the divided `pgt_1Hz` timebase from `clk100`. It generalises the fixed single-digit timer controller with configurable digit count, divide ratio, multi-key rejection, press/release tracking, a full flag and optional debounce.

---
 rtl/timer_entrada_param_if.sv | 39 +++
 rtl/timer_entrada_param.sv | 175 +++++++++++++++++
 tb/tb_timer_entrada_param.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_entrada_param_if.sv
// Keypad-side bundle for timer_entrada_param: key/enable/clear in, BCD strobe, entry register and timebase out.
// Latency: none, this is wiring only.
// Backpressure: none; loadn is a one-shot strobe with no ready, so the consumer must take it when it appears.
//
// Ports (as seen by the slave, i.e. the controller):
//   key[9:0]  in   one-hot keypad, active-high, key[n] is digit n
//   enablen   in   active-low entry enable
//   zeron     in   synchronous active-low clear of digits/count/full
//   D[3:0]    out  BCD code of the last accepted key
//   loadn     out  active-low one-cycle strobe per accepted key
//   pgt_1Hz   out  divided timebase, 50 % duty
//   digits    out  entry register, newest digit in [3:0]
//   count     out  digits entered, saturating at DIGITS
//   full      out  count == DIGITS
interface timer_entrada_param_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [9:0]          key;
    logic                enablen;
    logic                zeron;
    logic [3:0]          D;
    logic                loadn;
    logic                pgt_1Hz;
    logic [4*DIGITS-1:0] digits;
    logic [CW-1:0]       count;
    logic                full;

    modport master (
        output key, enablen, zeron,
        input  D, loadn, pgt_1Hz, digits, count, full
    );

    modport slave (
        input  key, enablen, zeron,
        output D, loadn, pgt_1Hz, digits, count, full
    );
endinterface

// File: rtl/timer_entrada_param.sv
// Keypad entry and 1 Hz timebase controller: encodes each new one-hot key press to BCD, strobes loadn, shifts digits.
// Latency: key to loadn/D/digits is 3 clk100 edges (3 + DEB_CYCLES with TIMER_ENTRY_DEBOUNCE_EN defined).
// Backpressure: none; presses while enablen=1 or full=1 are swallowed, a held key is never accepted twice.
//
// Ports: clk100 (clock), clearn (async active-low reset), bus (timer_entrada_param_if.slave, see interface file).
// Parameters: DIGITS entry digits (>=1), DIV clk100 cycles per pgt_1Hz period (even, >=2),
//             DEB_CYCLES stable cycles before accepting a key (debounce build only).
// Optional feature macro: TIMER_ENTRY_DEBOUNCE_EN adds a DEBOUNCE state between IDLE and accept.
module timer_entrada_param #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 100,
    parameter int DEB_CYCLES = 3
) (
    input  logic                 clk100,
    input  logic                 clearn,
    timer_entrada_param_if.slave bus
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int VW = $clog2(DIV);

    localparam logic [VW-1:0] DIV_LAST  = VW'(DIV - 1);
    localparam logic [VW-1:0] DIV_HALF  = VW'(DIV / 2);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DIGITS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
`ifdef TIMER_ENTRY_DEBOUNCE_EN
    localparam logic [1:0] ST_DEB  = 2'd2;
    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYCLES);
`endif

    logic [9:0]    s1, s2;
    logic [1:0]    state, state_nxt;
    logic          s2_valid;
    logic          accept;
    logic [3:0]    code;
    logic [3:0]    d_q;
    logic          loadn_q;
    logic [DW-1:0] digits_q, digits_shift;
    logic [CW-1:0] count_q;
    logic          full_q;
    logic [VW-1:0] div_cnt, div_nxt;
    logic          pgt_q;

`ifdef TIMER_ENTRY_DEBOUNCE_EN
    logic [DBW-1:0] deb_cnt, deb_cnt_nxt;
    logic [9:0]     deb_val, deb_val_nxt;
`endif

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign s2_valid = (s2 != '0) && ((s2 & (s2 - 10'd1)) == '0);

    // Only meaningful when s2_valid; multi-bit patterns never reach an accept.
    always_comb begin
        code = '0;
        for (int i = 0; i < 10; i++) begin
            if (s2[i]) code = 4'(i);
        end
    end

    generate
        if (DIGITS == 1) begin : g_one_digit
            assign digits_shift = code;
        end else begin : g_multi_digit
            assign digits_shift = {digits_q[DW-5:0], code};
        end
    endgenerate

    // Entry FSM. accept is the single point where a press becomes a digit;
    // enablen/full are sampled here so a refused press still goes to HELD.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
`ifdef TIMER_ENTRY_DEBOUNCE_EN
        deb_cnt_nxt = deb_cnt;
        deb_val_nxt = deb_val;
`endif
        case (state)
            ST_IDLE: begin
                if (s2_valid) begin
`ifdef TIMER_ENTRY_DEBOUNCE_EN
                    state_nxt   = ST_DEB;
                    deb_cnt_nxt = DBW'(1);
                    deb_val_nxt = s2;
`else
                    state_nxt = ST_HELD;
                    accept    = !bus.enablen && !full_q;
`endif
                end
            end
            ST_HELD: begin
                if (s2 == '0) state_nxt = ST_IDLE;
            end
`ifdef TIMER_ENTRY_DEBOUNCE_EN
            ST_DEB: begin
                // deb_val is one-hot, so any change (other key, release, chord) lands here.
                if (s2 != deb_val) begin
                    state_nxt = ST_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    accept    = !bus.enablen && !full_q;
                end else begin
                    deb_cnt_nxt = deb_cnt + DBW'(1);
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            s1       <= '0;
            s2       <= '0;
            state    <= ST_IDLE;
            d_q      <= '0;
            loadn_q  <= 1'b1;
            digits_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            s1      <= bus.key;
            s2      <= s1;
            state   <= state_nxt;
            // A clear landing on the accept edge suppresses the strobe but D still tracks the key.
            loadn_q <= !(accept && bus.zeron);
            if (accept) d_q <= code;
            if (!bus.zeron) begin
                digits_q <= '0;
                count_q  <= '0;
                full_q   <= 1'b0;
            end else if (accept) begin
                // accept implies !full, so count cannot overflow past DIGITS.
                digits_q <= digits_shift;
                count_q  <= count_q + CW'(1);
                full_q   <= ((count_q + CW'(1)) == COUNT_MAX);
            end
        end
    end

`ifdef TIMER_ENTRY_DEBOUNCE_EN
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            deb_cnt <= '0;
            deb_val <= '0;
        end else begin
            deb_cnt <= deb_cnt_nxt;
            deb_val <= deb_val_nxt;
        end
    end
`endif

    // Free-running divider; pgt_1Hz is registered from the next count so it is glitch-free
    // and equals (cnt >= DIV/2) for the count held in div_cnt.
    assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + VW'(1);

    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            div_cnt <= '0;
            pgt_q   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pgt_q   <= (div_nxt >= DIV_HALF);
        end
    end

    assign bus.D       = d_q;
    assign bus.loadn   = loadn_q;
    assign bus.pgt_1Hz = pgt_q;
    assign bus.digits  = digits_q;
    assign bus.count   = count_q;
    assign bus.full    = full_q;
endmodule

// File: tb/tb_timer_entrada_param.sv
// Testbench for timer_entrada_param: directed scenarios plus random key traffic against a behavioural model.
// Latency: model expectations are compared on every falling edge, half a cycle after the DUT updates.
// Backpressure: not applicable; the bench drives keys freely and only observes strobes.
module tb_timer_entrada_param;
    localparam int DIGITS = 4;
    localparam int DIV    = 100;
    localparam int DEB    = 3;
`ifdef TIMER_ENTRY_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic clk100 = 1'b0;
    logic clearn = 1'b0;
    always #5 clk100 = ~clk100;

    timer_entrada_param_if #(.DIGITS(DIGITS)) bus ();

    timer_entrada_param #(
        .DIGITS(DIGITS), .DIV(DIV), .DEB_CYCLES(DEB)
    ) dut (
        .clk100(clk100),
        .clearn(clearn),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    // armed: the keypad has been seen idle (s2 == 0) since the last valid press,
    // so the next one-hot reading is a new press.
    logic [9:0]  m_s1, m_s2;
    bit          m_armed;
    logic [3:0]  m_d;
    logic        m_loadn;
    logic [15:0] m_dig;
    int          m_cnt;
    int          m_edges;
`ifdef TIMER_ENTRY_DEBOUNCE_EN
    int          m_deb;
    logic [9:0]  m_debv;
`endif

    function automatic bit one_hot(logic [9:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [3:0] code_of(logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    always @(posedge clk100 or negedge clearn) begin
        bit fire;
        if (!clearn) begin
            m_s1 = '0; m_s2 = '0; m_armed = 1; m_d = '0; m_loadn = 1'b1;
            m_dig = '0; m_cnt = 0; m_edges = 0;
`ifdef TIMER_ENTRY_DEBOUNCE_EN
            m_deb = 0; m_debv = '0;
`endif
        end else begin
            fire = 0;
            m_edges++;
            m_loadn = 1'b1;
            if (m_armed && one_hot(m_s2)) begin
`ifdef TIMER_ENTRY_DEBOUNCE_EN
                if (m_deb == 0) begin
                    m_deb = 1; m_debv = m_s2;
                end else if (m_s2 != m_debv) begin
                    m_deb = 0;
                end else if (m_deb == DEB) begin
                    fire = 1; m_deb = 0; m_armed = 0;
                end else begin
                    m_deb++;
                end
`else
                fire = 1; m_armed = 0;
`endif
            end else if (m_armed) begin
`ifdef TIMER_ENTRY_DEBOUNCE_EN
                m_deb = 0;
`endif
            end else if (m_s2 == '0) begin
                m_armed = 1;
            end
            if (fire && !bus.enablen && m_cnt < DIGITS) begin
                m_d = code_of(m_s2);
                if (bus.zeron) begin
                    m_loadn = 1'b0;
                    m_dig   = {m_dig[11:0], code_of(m_s2)};
                    m_cnt++;
                end
            end
            if (!bus.zeron) begin
                m_dig = '0; m_cnt = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.key;
        end
    end

    function automatic logic [25:0] dut_snap();
        return {bus.D, bus.loadn, bus.pgt_1Hz, bus.digits, bus.count, bus.full};
    endfunction

    function automatic logic [25:0] mdl_snap();
        logic pgt_exp;
        pgt_exp = (m_edges % DIV) >= (DIV / 2);
        return {m_d, m_loadn, pgt_exp, m_dig, 3'(m_cnt), 1'(m_cnt == DIGITS)};
    endfunction

    task automatic drive(input logic [9:0] k, input logic en_n, input logic z_n);
        bus.key = k; bus.enablen = en_n; bus.zeron = z_n;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive('0, 1'b1, 1'b1);
        clearn = 1'b0;
        #23;
        total++; if (bus.D !== 4'd0)       begin bad++; $display("FAIL reset_D got=%h want=0", bus.D); end
        total++; if (bus.loadn !== 1'b1)   begin bad++; $display("FAIL reset_loadn got=%b want=1", bus.loadn); end
        total++; if (bus.pgt_1Hz !== 1'b0) begin bad++; $display("FAIL reset_pgt got=%b want=0", bus.pgt_1Hz); end
        total++; if (bus.digits !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h want=0", bus.digits); end
        total++; if (bus.count !== 3'd0)   begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
    endtask

    task automatic test_single_key();
        int strobes = 0;
        @(negedge clk100);
        clearn = 1'b1;
        drive(10'b10_0000_0000, 1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk100);
            if (bus.loadn === 1'b0) strobes++;
            total++;
            if (dut_snap() !== mdl_snap()) begin
                bad++; $display("FAIL single_model cyc=%0d dut=%h model=%h", c, dut_snap(), mdl_snap());
            end
            if (c < LAT + 2) begin
                total++;
                if (bus.loadn !== ((c == LAT - 1) ? 1'b0 : 1'b1)) begin
                    bad++; $display("FAIL single_strobe_time edge=%0d loadn=%b", c + 1, bus.loadn);
                end
            end
        end
        total++; if (strobes != 1)             begin bad++; $display("FAIL single_strobes got=%0d want=1", strobes); end
        total++; if (bus.D !== 4'd9)           begin bad++; $display("FAIL single_D got=%0d want=9", bus.D); end
        total++; if (bus.digits[3:0] !== 4'd9) begin bad++; $display("FAIL single_digit got=%h want=9", bus.digits[3:0]); end
        total++; if (bus.count !== 3'd1)       begin bad++; $display("FAIL single_count got=%0d want=1", bus.count); end
    endtask

    task automatic test_sequence();
        logic [9:0] pat [4];
        int strobes = 0;
        pat[0] = 10'b00_0000_0000; pat[1] = 10'b01_0000_0000;
        pat[2] = 10'b00_0000_0000; pat[3] = 10'b00_0000_0001;
        for (int p = 0; p < 5; p++) begin
            drive((p < 4) ? pat[p] : 10'd0, 1'b0, 1'b1);
            for (int c = 0; c < 6 + int'($urandom_range(0, 6)); c++) begin
                @(negedge clk100);
                if (bus.loadn === 1'b0) strobes++;
                total++;
                if (dut_snap() !== mdl_snap()) begin
                    bad++; $display("FAIL seq_model p=%0d cyc=%0d dut=%h model=%h", p, c, dut_snap(), mdl_snap());
                end
            end
        end
        total++; if (strobes != 2)               begin bad++; $display("FAIL seq_strobes got=%0d want=2", strobes); end
        total++; if (bus.digits[11:0] !== 12'h980) begin bad++; $display("FAIL seq_digits got=%h want=980", bus.digits[11:0]); end
        total++; if (bus.count !== 3'd3)         begin bad++; $display("FAIL seq_count got=%0d want=3", bus.count); end
    endtask

    task automatic test_enable();
        int strobes = 0;
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: drive(10'b01_0000_0000, 1'b1, 1'b1);
                1: drive(10'b01_0000_0000, 1'b0, 1'b1);
                2: drive(10'd0, 1'b0, 1'b1);
                default: drive(10'b01_0000_0000, 1'b0, 1'b1);
            endcase
            for (int c = 0; c < 10; c++) begin
                @(negedge clk100);
                if (bus.loadn === 1'b0) strobes++;
                total++;
                if (dut_snap() !== mdl_snap()) begin
                    bad++; $display("FAIL en_model ph=%0d cyc=%0d dut=%h model=%h", ph, c, dut_snap(), mdl_snap());
                end
            end
            if (ph == 1) begin
                total++;
                if (strobes != 0 || bus.D !== 4'd0 || bus.digits !== 16'h0980) begin
                    bad++; $display("FAIL en_blocked strobes=%0d D=%0d digits=%h want 0/0/0980", strobes, bus.D, bus.digits);
                end
            end
        end
        drive(10'd0, 1'b0, 1'b1);
        repeat (5) @(negedge clk100);
        total++; if (strobes != 1)           begin bad++; $display("FAIL en_repress got=%0d want=1", strobes); end
        total++; if (bus.digits !== 16'h9808) begin bad++; $display("FAIL en_digits got=%h want=9808", bus.digits); end
    endtask

    task automatic test_full();
        int strobes = 0;
        drive(10'd0, 1'b0, 1'b0);
        @(negedge clk100);
        drive(10'b00_0000_0011, 1'b0, 1'b1);
        for (int p = 0; p < 11; p++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk100);
                if (bus.loadn === 1'b0) strobes++;
                total++;
                if (dut_snap() !== mdl_snap()) begin
                    bad++; $display("FAIL full_model p=%0d cyc=%0d dut=%h model=%h", p, c, dut_snap(), mdl_snap());
                end
            end
            if (p == 0) begin
                total++; if (strobes != 0) begin bad++; $display("FAIL full_chord got=%0d want=0", strobes); end
            end
            if (p[0]) drive(10'd0, 1'b0, 1'b1);
            else      drive(10'(1) << $urandom_range(0, 9), 1'b0, 1'b1);
        end
        total++; if (strobes != 4)      begin bad++; $display("FAIL full_strobes got=%0d want=4", strobes); end
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", bus.full); end
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.count); end
        drive(10'd0, 1'b0, 1'b0);
        @(negedge clk100);
        drive(10'd0, 1'b0, 1'b1);
        total++;
        if ({bus.digits, bus.count, bus.full} !== 20'h0) begin
            bad++; $display("FAIL full_clear digits=%h count=%0d full=%b want 0", bus.digits, bus.count, bus.full);
        end
    endtask

    task automatic test_random();
        logic [9:0] k;
        int r, a, b;
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 9);
            b = (a + 1 + $urandom_range(0, 8)) % 10;
            if (r < 5)      k = 10'(1) << a;
            else if (r < 8) k = '0;
            else            k = (10'(1) << a) | (10'(1) << b);
            drive(k, ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) != 0));
            for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
                @(negedge clk100);
                total++;
                if (dut_snap() !== mdl_snap()) begin
                    bad++; $display("FAIL rand_model it=%0d cyc=%0d dut=%h model=%h", it, c, dut_snap(), mdl_snap());
                end
            end
        end
        drive(10'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk100);
    endtask

    task automatic test_reset_mid_press();
        int strobes = 0;
        drive(10'd0, 1'b0, 1'b0);
        @(negedge clk100);
        drive(10'b00_0010_0000, 1'b0, 1'b1);
        repeat (10) @(negedge clk100);
        #2 clearn = 1'b0;
        @(negedge clk100);
        clearn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk100);
            if (bus.loadn === 1'b0) strobes++;
            total++;
            if (dut_snap() !== mdl_snap()) begin
                bad++; $display("FAIL midrst_model cyc=%0d dut=%h model=%h", c, dut_snap(), mdl_snap());
            end
        end
        total++;
        if (strobes != 1 || bus.D !== 4'd5 || bus.digits !== 16'h0005 || bus.count !== 3'd1) begin
            bad++; $display("FAIL midrst_repress strobes=%0d D=%0d digits=%h count=%0d want 1/5/0005/1",
                            strobes, bus.D, bus.digits, bus.count);
        end
        drive(10'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk100);
    endtask

    task automatic test_divider();
        @(negedge clk100);
        clearn = 1'b0;
        @(negedge clk100);
        clearn = 1'b1;
        for (int e = 1; e <= 250; e++) begin
            @(negedge clk100);
            total++;
            if (bus.pgt_1Hz !== 1'(((e % DIV) >= DIV / 2))) begin
                bad++; $display("FAIL div_pgt edge=%0d got=%b", e, bus.pgt_1Hz);
            end
        end
        #2 clearn = 1'b0;
        #1;
        total++; if (bus.pgt_1Hz !== 1'b0) begin bad++; $display("FAIL div_async_clear got=%b want=0", bus.pgt_1Hz); end
        @(negedge clk100);
        clearn = 1'b1;
        for (int e = 1; e <= 120; e++) begin
            @(negedge clk100);
            total++;
            if (bus.pgt_1Hz !== 1'(((e % DIV) >= DIV / 2))) begin
                bad++; $display("FAIL div_restart edge=%0d got=%b", e, bus.pgt_1Hz);
            end
        end
    endtask

`ifdef TIMER_ENTRY_DEBOUNCE_EN
    task automatic test_debounce();
        int strobes = 0;
        drive(10'd0, 1'b0, 1'b0);
        @(negedge clk100);
        drive(10'b00_0000_1000, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk100);
            if (c == 1) drive(10'd0, 1'b0, 1'b1);
            if (bus.loadn === 1'b0) strobes++;
        end
        total++; if (strobes != 0) begin bad++; $display("FAIL deb_glitch got=%0d want=0", strobes); end
        drive(10'b00_0001_0000, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk100);
            if (c == 3) drive(10'd0, 1'b0, 1'b1);
            if (bus.loadn === 1'b0) strobes++;
            total++;
            if (bus.loadn !== ((c == 5) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL deb_press_time edge=%0d loadn=%b", c + 1, bus.loadn);
            end
        end
        total++; if (strobes != 1 || bus.D !== 4'd4) begin
            bad++; $display("FAIL deb_press strobes=%0d D=%0d want 1/4", strobes, bus.D);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_enable();
        test_full();
        test_random();
        test_reset_mid_press();
`ifdef TIMER_ENTRY_DEBOUNCE_EN
        test_debounce();
`endif
        test_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
